alu_multicycle: RTL and testbench

//  Parametrised, registered successor to the 8-bit combinational ALU. It accepts one

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_comb_w.sv | 58 +++++
 rtl/alu_multicycle.sv | 187 ++++++++++++++++++
 tb/tb_alu_multicycle.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag helpers
// for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL1 = 4'h6;
    localparam logic [3:0] OP_SHR1 = 4'h7;
    localparam logic [3:0] OP_ADC  = 4'h8;
    localparam logic [3:0] OP_SBC  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_SHLN = 4'hB;
    localparam logic [3:0] OP_SHRN = 4'hC;
    localparam logic [3:0] OP_ROL  = 4'hD;
    localparam logic [3:0] OP_ROR  = 4'hE;
    localparam logic [3:0] OP_RSVD = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    function automatic flags_t make_flags(
        input logic is_zero,
        input logic msb,
        input logic c,
        input logic v
    );
        flags_t f;
        f.z = is_zero;
        f.c = c;
        f.n = msb;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_comb_w.sv
// Single-cycle ALU datapath: arithmetic, logic,
// one-bit shifts and rotates through carry.
module alu_comb_w
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] ext;
    logic           cin_eff;

    // Opcode decode; unused opcodes produce zero with flags clear
    always_comb begin
        cin_eff    = ((op_i == OP_ADC) || (op_i == OP_SBC)) ? cin_i : 1'b0;
        ext        = '0;
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        case (op_i)
            OP_ADD, OP_ADC: begin
                ext = {1'b0, a_i} + {1'b0, b_i}
                    + {{WIDTH{1'b0}}, cin_eff};
                result_o   = ext[MSB:0];
                carry_o    = ext[WIDTH];
                overflow_o = (a_i[MSB] == b_i[MSB])
                          && (ext[MSB] != a_i[MSB]);
            end
            OP_SUB, OP_SBC: begin
                ext = {1'b0, a_i} - {1'b0, b_i}
                    - {{WIDTH{1'b0}}, cin_eff};
                result_o   = ext[MSB:0];
                carry_o    = ext[WIDTH];
                overflow_o = (a_i[MSB] != b_i[MSB])
                          && (ext[MSB] != a_i[MSB]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            OP_SHL1: {carry_o, result_o} = {a_i, 1'b0};
            OP_SHR1: {result_o, carry_o} = {1'b0, a_i};
            OP_ROL:  {carry_o, result_o} = {a_i, cin_i};
            OP_ROR:  {result_o, carry_o} = {cin_i, a_i};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshake, iterative
// multiply and variable shifts, and the flag register.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             clr_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam int CW = SHW + 1;

    state_t             state_q;
    logic [WIDTH-1:0]   opa_q;
    logic [3:0]         op_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   result_q;
    flags_t             flags_q;

    logic [WIDTH-1:0]   comb_res;
    logic               comb_c;
    logic               comb_v;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH-1:0]   shl_nx;
    logic [WIDTH-1:0]   shr_nx;

    logic               is_shift;
    logic               iter_d;
    logic [CW-1:0]      cnt_d;
    logic               fin_d;
    logic [WIDTH-1:0]   res_d;
    logic               c_d;
    logic               v_d;
    flags_t             flags_d;

    alu_comb_w #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a_i       (a),
        .b_i       (b),
        .op_i      (op),
        .cin_i     (flags_q.c),
        .result_o  (comb_res),
        .carry_o   (comb_c),
        .overflow_o(comb_v)
    );

    // One step of shift-add multiply and of the bitwise shifts
    always_comb begin
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, opa_q} : '0);
        prod_nx = {mul_sum, prod_q[WIDTH-1:1]};
        shl_nx  = {opa_q[WIDTH-2:0], 1'b0};
        shr_nx  = {1'b0, opa_q[WIDTH-1:1]};
    end

    // Whether this edge completes an op, and what it yields
    always_comb begin
        is_shift = (op == OP_SHLN) || (op == OP_SHRN);
        iter_d   = (op == OP_MUL)
                || (is_shift && (b[SHW-1:0] != '0));
        cnt_d    = (op == OP_MUL) ? CW'(WIDTH)
                                  : CW'(b[SHW-1:0]);
        fin_d    = 1'b0;
        res_d    = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !iter_d) begin
                    fin_d = 1'b1;
                    if (is_shift) begin
                        res_d = a;
                    end else begin
                        res_d = comb_res;
                        c_d   = comb_c;
                        v_d   = comb_v;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    fin_d = 1'b1;
                    if (op_q == OP_MUL) begin
                        res_d = prod_nx[WIDTH-1:0];
                        c_d   = |prod_nx[2*WIDTH-1:WIDTH];
                    end else if (op_q == OP_SHLN) begin
                        res_d = shl_nx;
                        c_d   = opa_q[WIDTH-1];
                    end else begin
                        res_d = shr_nx;
                        c_d   = opa_q[0];
                    end
                end
            end
            default: ;
        endcase
        flags_d = make_flags(res_d == '0, res_d[WIDTH-1],
                             c_d, v_d);
    end

    // Sequencing FSM with operand, iteration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        opa_q  <= a;
                        op_q   <= op;
                        cnt_q  <= cnt_d;
                        prod_q <= {{WIDTH{1'b0}}, b};
                        if (fin_d) begin
                            result_q <= res_d;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q  <= cnt_q - CW'(1);
                    prod_q <= prod_nx;
                    if (op_q == OP_SHLN) begin
                        opa_q <= shl_nx;
                    end else if (op_q == OP_SHRN) begin
                        opa_q <= shr_nx;
                    end
                    if (fin_d) begin
                        result_q <= res_d;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Flag register: loads on completion, clear takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (clr_flags) begin
            flags_q <= '0;
        end else if (fin_d) begin
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = flags_q.z;
    assign carry     = flags_q.c;
    assign negative  = flags_q.n;
    assign overflow  = flags_q.v;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised bench for alu_multicycle against a
// transaction-level reference model.
module tb_alu_multicycle;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       clr_flags;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       negative;
    logic       overflow;

    logic        iv16;
    logic        ir16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [3:0]  op16;
    logic        clr16;
    logic        ov16;
    logic        or16;
    logic [15:0] res16;
    logic        z16;
    logic        c16;
    logic        n16;
    logic        v16;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;
    bit rnd_clr = 0;

    int         lat;
    logic [7:0] r;
    logic [3:0] f;

    alu_multicycle #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .op(op),
        .clr_flags(clr_flags), .out_valid(out_valid),
        .out_ready(out_ready), .result(result),
        .zero(zero), .carry(carry), .negative(negative),
        .overflow(overflow)
    );

    alu_multicycle #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16),
        .in_ready(ir16), .a(a16), .b(b16), .op(op16),
        .clr_flags(clr16), .out_valid(ov16),
        .out_ready(or16), .result(res16),
        .zero(z16), .carry(c16), .negative(n16),
        .overflow(v16)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: result, carry, overflow and latency of one op (8-bit)
    function automatic void ref_op(
        input int ua, input int ub, input int opc, input bit cin,
        output int rr, output bit cc, output bit vv, output int ll);
        longint sa, sb, s;
        int ci, n;
        longint p;
        rr = 0; cc = 0; vv = 0; ll = 1;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        ci = (opc == 8 || opc == 9) ? int'(cin) : 0;
        n  = ub % 8;
        case (opc)
            0, 8: begin
                s  = ua + ub + ci;
                rr = int'(s % 256);
                cc = s >= 256;
                s  = sa + sb + ci;
                vv = (s > 127) || (s < -128);
            end
            1, 9: begin
                s  = ua - ub - ci;
                rr = int'((s + 512) % 256);
                cc = ua < ub + ci;
                s  = sa - sb - ci;
                vv = (s > 127) || (s < -128);
            end
            2: rr = ua & ub;
            3: rr = ua | ub;
            4: rr = ua ^ ub;
            5: rr = 255 - ua;
            6: begin rr = (ua * 2) % 256; cc = ua >= 128; end
            7: begin rr = ua / 2; cc = ua % 2 == 1; end
            10: begin
                p  = ua * ub;
                rr = int'(p % 256);
                cc = p >= 256;
                ll = 9;
            end
            11: begin
                if (n == 0) rr = ua;
                else begin
                    rr = (ua << n) % 256;
                    cc = ((ua >> (8 - n)) & 1) == 1;
                end
                ll = n + 1;
            end
            12: begin
                if (n == 0) rr = ua;
                else begin
                    rr = ua >> n;
                    cc = ((ua >> (n - 1)) & 1) == 1;
                end
                ll = n + 1;
            end
            13: begin rr = (ua * 2 + int'(cin)) % 256; cc = ua >= 128; end
            14: begin rr = ua / 2 + int'(cin) * 128; cc = ua % 2 == 1; end
            default: ;
        endcase
    endfunction

    // Model of the observable state, compared every cycle
    int       m_left = 0;
    bit       m_valid = 0;
    int       m_res = 0;
    bit [3:0] m_flg = 0;
    int       p_res = 0;
    bit       p_c = 0;
    bit       p_v = 0;

    always @(posedge clk) begin : model
        bit fin;
        int pr, pl;
        bit pc, pv;
        fin = 0;
        if (rst) begin
            m_left = 0; m_valid = 0; m_res = 0; m_flg = 0;
        end else begin
            if (m_valid) begin
                if (out_ready) m_valid = 0;
            end else if (m_left > 0) begin
                m_left--;
                fin = (m_left == 0);
            end else if (in_valid) begin
                ref_op(int'(a), int'(b), int'(op), m_flg[2],
                       pr, pc, pv, pl);
                p_res = pr; p_c = pc; p_v = pv;
                m_left = pl - 1;
                fin = (m_left == 0);
            end
            if (clr_flags) m_flg = 0;
            else if (fin)
                m_flg = {p_res == 0, p_c, p_res >= 128, p_v};
            if (fin) begin
                m_res = p_res;
                m_valid = 1;
            end
        end
        #1;
        if (chk_on) begin
            chk("out_valid", longint'(out_valid), longint'(m_valid));
            chk("in_ready", longint'(in_ready),
                longint'(!m_valid && m_left == 0));
            chk("result", longint'(result), longint'(m_res));
            chk("flags", longint'({zero, carry, negative, overflow}),
                longint'(m_flg));
        end
    end

    task automatic tick();
        @(negedge clk);
        clr_flags = rnd_clr && ($urandom_range(0, 5) == 0);
    endtask

    task automatic run_op(
        input logic [7:0] ta, input logic [7:0] tb_,
        input logic [3:0] top, input int hold, input bit clr0,
        output int l, output logic [7:0] rr, output logic [3:0] ff);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        a = ta; b = tb_; op = top;
        in_valid = 1; out_ready = 0;
        if (clr0) clr_flags = 1;
        tick();
        in_valid = 0;
        l = 1;
        while (!out_valid && l < 40) begin
            in_valid = 1'($urandom);
            a = 8'($urandom); op = 4'($urandom);
            tick();
            l++;
        end
        rr = result;
        ff = {zero, carry, negative, overflow};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
            tick();
        end
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; clr_flags = 0;
        a = 0; b = 0; op = 0;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0; op16 = 0; clr16 = 0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, carry, negative, overflow}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        rst = 0;
        chk_on = 1;
        tick();

        run_op(8'h7F, 8'h01, 4'h0, 0, 0, lat, r, f);
        chk("add_lat", lat, 1);
        chk("add_res", r, 8'h80);
        chk("add_flg", f, 4'b0011);

        run_op(8'h10, 8'h20, 4'h1, 0, 0, lat, r, f);
        chk("sub_res", r, 8'hF0);
        chk("sub_flg", f, 4'b0110);
        run_op(8'h05, 8'h01, 4'h9, 0, 0, lat, r, f);
        chk("sbc_res", r, 8'h03);
        chk("sbc_flg", f, 4'b0000);

        run_op(8'h13, 8'h11, 4'hA, 0, 0, lat, r, f);
        chk("mul_lat", lat, 9);
        chk("mul_res", r, 8'h43);
        chk("mul_c", f[2], 1);

        run_op(8'h81, 8'h01, 4'hB, 0, 0, lat, r, f);
        chk("shln1_lat", lat, 2);
        chk("shln1_res", r, 8'h02);
        chk("shln1_c", f[2], 1);
        run_op(8'h81, 8'h00, 4'hB, 0, 0, lat, r, f);
        chk("shln0_lat", lat, 1);
        chk("shln0_res", r, 8'h81);
        chk("shln0_c", f[2], 0);

        run_op(8'h01, 8'h00, 4'h7, 0, 0, lat, r, f);
        chk("shr1_flg", f, 4'b1100);
        run_op(8'h01, 8'h00, 4'hE, 0, 0, lat, r, f);
        chk("ror_res", r, 8'h80);
        chk("ror_c", f[2], 1);

        run_op(8'h01, 8'h02, 4'h0, 5, 0, lat, r, f);
        chk("bp_res", result, 8'h03);
        chk("bp_flg", f, 4'b0000);

        run_op(8'h7F, 8'h01, 4'h0, 0, 1, lat, r, f);
        chk("clr_res", r, 8'h80);
        chk("clr_flg", f, 4'b0000);

        a = 8'h13; b = 8'h11; op = 4'hA; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (3) tick();
        rst = 1;
        #1;
        chk("rmid_result", result, 0);
        chk("rmid_flags", {zero, carry, negative, overflow}, 0);
        chk("rmid_in_ready", in_ready, 1);
        chk("rmid_out_valid", out_valid, 0);
        tick();
        rst = 0;
        tick();
        run_op(8'h22, 8'h11, 4'h0, 0, 0, lat, r, f);
        chk("radd_lat", lat, 1);
        chk("radd_res", r, 8'h33);

        a16 = 16'h0000; b16 = 16'h0001; op16 = 4'h1; iv16 = 1;
        tick();
        iv16 = 0;
        chk("w16_sub_valid", ov16, 1);
        chk("w16_sub_res", res16, 16'hFFFF);
        chk("w16_sub_c", c16, 1);
        or16 = 1;
        tick();
        or16 = 0;
        a16 = 16'hFFFF; b16 = 16'h0000; op16 = 4'h8; iv16 = 1;
        tick();
        iv16 = 0;
        chk("w16_adc_valid", ov16, 1);
        chk("w16_adc_res", res16, 16'h0000);
        chk("w16_adc_zc", {z16, c16}, 2'b11);
        or16 = 1;
        tick();
        or16 = 0;

        rnd_clr = 1;
        for (int k = 0; k < 300; k++) begin
            run_op(8'($urandom), 8'($urandom), 4'($urandom),
                   int'($urandom_range(0, 3)), 0, lat, r, f);
        end
        rnd_clr = 0;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
